// File: rtl/fwpic_pkg.sv
// Shared types and helpers for the fwpic interrupt-controller bus fabric.
// Holds the arbiter state encoding and the round-robin index search.
package fwpic_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned RR_MAX_N        = 32;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    // First set bit of req scanning last+1, last+2, ... with wrap at n.
    // Returns 0 when req is empty; callers qualify with |req.
    function automatic int unsigned rr_next(
        input logic [RR_MAX_N-1:0] req,
        input int unsigned         last,
        input int unsigned         n
    );
        int unsigned idx;
        int unsigned j;
        bit          found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
            if (k <= n) begin
                j = last + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!found && req[j]) begin
                    found = 1'b1;
                    idx   = j;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fwpic_rr_pick.sv
// Combinational round-robin picker: request vector plus last-served index
// in, one-hot grant, binary index and valid out.
module fwpic_rr_pick
    import fwpic_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]                   req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] last,
    output logic [N-1:0]                   onehot,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx,
    output logic                           valid
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [RR_MAX_N-1:0] req_ext;
    int unsigned         pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = rr_next(req_ext, int'(last), N);
        valid          = |req;
        idx            = IW'(pick);
        onehot         = '0;
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fwpic_wb_arb.sv
// Round-robin Wishbone arbiter sharing the fwpic register target port
// between N_INIT initiators, with cyc-framed grants and a no-ack timeout.
module fwpic_wb_arb
    import fwpic_pkg::*;
#(
    parameter int unsigned N_INIT  = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_INIT*ADDR_W-1:0]     i_adr,
    input  logic [N_INIT*DATA_W-1:0]     i_dat_w,
    input  logic [N_INIT*(DATA_W/8)-1:0] i_sel,
    input  logic [N_INIT-1:0]            i_we,
    input  logic [N_INIT-1:0]            i_cyc,
    input  logic [N_INIT-1:0]            i_stb,
    output logic [DATA_W-1:0]            i_dat_r,
    output logic [N_INIT-1:0]            i_ack,
    output logic [N_INIT-1:0]            i_err,
    output logic [ADDR_W-1:0]            t_adr,
    output logic [DATA_W-1:0]            t_dat_w,
    output logic [DATA_W/8-1:0]          t_sel,
    output logic                         t_we,
    output logic                         t_cyc,
    output logic                         t_stb,
    input  logic [DATA_W-1:0]            t_dat_r,
    input  logic                         t_ack,
    output logic [N_INIT-1:0]            gnt
);

    localparam int unsigned IW    = (N_INIT > 1) ? $clog2(N_INIT) : 1;
    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    arb_state_t        state, state_n;
    logic [N_INIT-1:0] gnt_n;
    logic [IW-1:0]     gidx, gidx_n;
    logic [IW-1:0]     last, last_n;
    logic [CW-1:0]     cnt, cnt_n;

    logic [N_INIT-1:0] pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;

    logic busy;
    logic sel_cyc;
    logic sel_stb;
    logic sel_we;
    logic stall;
    logic to_hit;

    fwpic_rr_pick #(
        .N(N_INIT)
    ) u_pick (
        .req    (i_cyc),
        .last   (last),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Target-side mux from the granted slice; quiet while idle.
    always_comb begin
        busy    = (state == BUSY);
        sel_cyc = i_cyc[gidx];
        sel_stb = i_stb[gidx];
        sel_we  = i_we[gidx];
        stall   = busy && sel_cyc && sel_stb && !t_ack;
        to_hit  = (TIMEOUT != 0) && stall && (cnt == TO_LIMIT);

        t_cyc   = busy && sel_cyc;
        t_stb   = busy && sel_stb && !to_hit;
        t_we    = busy && sel_we;
        t_adr   = busy ? i_adr[gidx*ADDR_W +: ADDR_W]   : '0;
        t_dat_w = busy ? i_dat_w[gidx*DATA_W +: DATA_W] : '0;
        t_sel   = busy ? i_sel[gidx*SEL_W +: SEL_W]     : '0;

        i_dat_r = t_dat_r;
        i_ack   = gnt & {N_INIT{t_ack}};
        i_err   = to_hit ? gnt : '0;
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        gidx_n  = gidx;
        last_n  = last;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (pick_valid) begin
                    state_n = BUSY;
                    gnt_n   = pick_oh;
                    gidx_n  = pick_idx;
                end
            end
            BUSY: begin
                if (!sel_cyc) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    last_n  = gidx;
                    cnt_n   = '0;
                end else if (stall && (TIMEOUT != 0)) begin
                    cnt_n = to_hit ? '0 : cnt + CW'(1);
                end else begin
                    cnt_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            gidx  <= '0;
            last  <= IW'(N_INIT - 1);
            cnt   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            gidx  <= gidx_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_fwpic_wb_arb.sv
// Scoreboard bench for fwpic_wb_arb: grant order and ack/data responses are
// queued as stimulus is driven and compared when the DUT produces them.
module tb_fwpic_wb_arb;

    logic        clk;
    logic        reset;
    logic [63:0] i_adr;
    logic [63:0] i_dat_w;
    logic [7:0]  i_sel;
    logic [1:0]  i_we;
    logic [1:0]  i_cyc;
    logic [1:0]  i_stb;
    logic [31:0] t_dat_r;
    logic        t_ack;

    logic [31:0] i_dat_r;
    logic [1:0]  i_ack;
    logic [1:0]  i_err;
    logic [31:0] t_adr;
    logic [31:0] t_dat_w;
    logic [3:0]  t_sel;
    logic        t_we;
    logic        t_cyc;
    logic        t_stb;
    logic [1:0]  gnt;

    logic [31:0] nt_dat_r;
    logic [1:0]  nt_ack;
    logic [1:0]  nt_err;
    logic [31:0] nt_adr;
    logic [31:0] nt_dat_w;
    logic [3:0]  nt_sel;
    logic        nt_we;
    logic        nt_cyc;
    logic        nt_stb;
    logic [1:0]  nt_gnt;

    fwpic_wb_arb #(
        .N_INIT(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)
    ) dut (
        .clock(clk), .reset(reset),
        .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we),
        .i_cyc(i_cyc), .i_stb(i_stb),
        .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err),
        .t_adr(t_adr), .t_dat_w(t_dat_w), .t_sel(t_sel), .t_we(t_we),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_dat_r(t_dat_r), .t_ack(t_ack),
        .gnt(gnt)
    );

    fwpic_wb_arb #(
        .N_INIT(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(0)
    ) dut_nt (
        .clock(clk), .reset(reset),
        .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we),
        .i_cyc(i_cyc), .i_stb(i_stb),
        .i_dat_r(nt_dat_r), .i_ack(nt_ack), .i_err(nt_err),
        .t_adr(nt_adr), .t_dat_w(nt_dat_w), .t_sel(nt_sel), .t_we(nt_we),
        .t_cyc(nt_cyc), .t_stb(nt_stb), .t_dat_r(t_dat_r), .t_ack(t_ack),
        .gnt(nt_gnt)
    );

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] data;
    } ack_exp_t;

    int       gnt_q[$];
    ack_exp_t ack_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    int       err_pulses = 0;
    logic [1:0] gnt_prev = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat);
        i_cyc[k]            = cyc;
        i_stb[k]            = stb;
        i_we[k]             = we;
        i_adr[k*32 +: 32]   = adr;
        i_dat_w[k*32 +: 32] = dat;
        i_sel[k*4 +: 4]     = 4'hF;
    endtask

    task automatic push_ack(input logic [1:0] mask, input logic [31:0] data);
        ack_exp_t e;
        e.mask = mask;
        e.data = data;
        ack_q.push_back(e);
    endtask

    // Returns at the first falling edge where initiator k holds the grant.
    task automatic wait_gnt(input int k);
        logic [1:0] want;
        int         n;
        want = 2'b01 << k;
        n    = 0;
        @(negedge clk);
        while (gnt !== want && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("gnt_wait", {62'd0, gnt}, {62'd0, want});
    endtask

    // One acked access by initiator k, then cyc drop and an optional re-request.
    task automatic serve(input int k, input logic [31:0] d, input bit rereq);
        wait_gnt(k);
        step();
        t_ack   = 1'b1;
        t_dat_r = d;
        push_ack(2'b01 << k, d);
        @(negedge clk);
        step();
        t_ack    = 1'b0;
        i_cyc[k] = 1'b0;
        i_stb[k] = 1'b0;
        step();
        if (rereq) begin
            i_cyc[k] = 1'b1;
            i_stb[k] = 1'b1;
        end
        @(negedge clk);
        check_eq("idle_gap", {62'd0, gnt}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && gnt !== 2'b00 && gnt_prev === 2'b00) begin
            if (gnt_q.size() == 0) begin
                check_eq("gnt_unexpected", {62'd0, gnt}, 64'd0);
            end else begin
                int k;
                k = gnt_q.pop_front();
                check_eq("gnt_order", {62'd0, gnt}, {62'd0, 2'b01 << k});
            end
        end
        gnt_prev = gnt;
    end

    always @(negedge clk) begin
        if (i_ack !== 2'b00) begin
            if (ack_q.size() == 0) begin
                check_eq("ack_unexpected", {62'd0, i_ack}, 64'd0);
            end else begin
                ack_exp_t e;
                e = ack_q.pop_front();
                check_eq("ack_mask", {62'd0, i_ack}, {62'd0, e.mask});
                check_eq("ack_data", {32'd0, i_dat_r}, {32'd0, e.data});
            end
        end
        if (i_err !== 2'b00) err_pulses++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nt_errs;
        reset   = 1'b1;
        i_adr   = '0;
        i_dat_w = '0;
        i_sel   = '0;
        i_we    = '0;
        i_cyc   = '0;
        i_stb   = '0;
        t_dat_r = '0;
        t_ack   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_gnt",   {62'd0, gnt},   64'd0);
        check_eq("rst_t_cyc", {63'd0, t_cyc}, 64'd0);
        check_eq("rst_t_stb", {63'd0, t_stb}, 64'd0);
        check_eq("rst_t_we",  {63'd0, t_we},  64'd0);
        check_eq("rst_ack",   {62'd0, i_ack}, 64'd0);
        check_eq("rst_err",   {62'd0, i_err}, 64'd0);

        // Single initiator 0 read
        step();
        reset = 1'b0;
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        gnt_q.push_back(0);
        @(negedge clk);
        check_eq("t1_cyc_lat", {63'd0, t_cyc}, 64'd0);
        step();
        @(negedge clk);
        check_eq("t1_cyc",   {63'd0, t_cyc}, 64'd1);
        check_eq("t1_stb",   {63'd0, t_stb}, 64'd1);
        check_eq("t1_adr",   {32'd0, t_adr}, 64'h4);
        check_eq("t1_sel",   {60'd0, t_sel}, 64'hF);
        serve(0, 32'hA5, 1'b0);

        // Simultaneous requests from reset, continuous rotation
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        serve(0, 32'hA0, 1'b1);
        serve(1, 32'hB1, 1'b1);
        serve(0, 32'hC0, 1'b0);
        serve(1, 32'hD1, 1'b0);

        // Locked read-modify-write frame by initiator 1
        step();
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
        gnt_q.push_back(1);
        wait_gnt(1);
        step();
        set_req(0, 1'b1, 1'b1, 1'b0, 32'hC, 32'h0);
        gnt_q.push_back(0);
        t_ack   = 1'b1;
        t_dat_r = 32'h11;
        push_ack(2'b10, 32'h11);
        @(negedge clk);
        step();
        t_ack    = 1'b0;
        i_stb[1] = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("lock_gnt_gap", {62'd0, gnt},   64'h2);
            check_eq("lock_stb_gap", {63'd0, t_stb}, 64'd0);
            step();
        end
        set_req(1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h22);
        @(negedge clk);
        check_eq("lock_gnt_wr", {62'd0, gnt},     64'h2);
        check_eq("lock_we",     {63'd0, t_we},    64'd1);
        check_eq("lock_dat_w",  {32'd0, t_dat_w}, 64'h22);
        step();
        t_ack   = 1'b1;
        t_dat_r = 32'h0;
        push_ack(2'b10, 32'h0);
        @(negedge clk);
        step();
        t_ack = 1'b0;
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_eq("lock_tcyc_drop", {63'd0, t_cyc}, 64'd0);
        serve(0, 32'h33, 1'b0);

        // Timeout after 4 stalled cycles, then ack winning at count 4
        err_pulses = 0;
        step();
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        gnt_q.push_back(0);
        wait_gnt(0);
        for (int unsigned n = 0; n <= 4; n++) begin
            if (n > 0) @(negedge clk);
            if (n < 4) begin
                check_eq("to_no_err", {62'd0, i_err}, 64'd0);
                check_eq("to_stb_on", {63'd0, t_stb}, 64'd1);
            end else begin
                check_eq("to_err",      {62'd0, i_err}, 64'h1);
                check_eq("to_stb_mask", {63'd0, t_stb}, 64'd0);
                check_eq("to_no_ack",   {62'd0, i_ack}, 64'd0);
            end
        end
        step();
        i_stb[0] = 1'b0;
        @(negedge clk);
        check_eq("to_err_once", {62'd0, i_err}, 64'd0);
        check_eq("to_gnt_hold", {62'd0, gnt},   64'h1);
        step();
        i_stb[0] = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        step();
        t_ack   = 1'b1;
        t_dat_r = 32'h5A;
        push_ack(2'b01, 32'h5A);
        @(negedge clk);
        check_eq("to_ack_wins_err", {62'd0, i_err}, 64'd0);
        check_eq("to_ack_wins_stb", {63'd0, t_stb}, 64'd1);
        step();
        t_ack = 1'b0;
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        check_eq("to_pulse_count", err_pulses, 64'd1);

        // Reset while initiator 0 holds the grant
        step();
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
        gnt_q.push_back(0);
        wait_gnt(0);
        step();
        reset = 1'b1;
        step();
        t_ack = 1'b1;
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h34, 32'h0);
        @(negedge clk);
        check_eq("mrst_t_cyc", {63'd0, t_cyc}, 64'd0);
        check_eq("mrst_gnt",   {62'd0, gnt},   64'd0);
        check_eq("mrst_ack",   {62'd0, i_ack}, 64'd0);
        check_eq("mrst_err",   {62'd0, i_err}, 64'd0);
        step();
        reset = 1'b0;
        t_ack = 1'b0;
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        serve(0, 32'h40, 1'b0);
        serve(1, 32'h41, 1'b0);

        // TIMEOUT=0 instance: long stall never errors, grant held
        step();
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
        gnt_q.push_back(0);
        wait_gnt(0);
        nt_errs = 0;
        for (int unsigned n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (nt_err !== 2'b00) nt_errs++;
        end
        check_eq("nt_no_err",   nt_errs,           64'd0);
        check_eq("nt_gnt_hold", {62'd0, nt_gnt},   64'h1);
        check_eq("nt_stb_hold", {63'd0, nt_stb},   64'd1);
        check_eq("nt_cyc_hold", {63'd0, nt_cyc},   64'd1);
        step();
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) step();

        check_eq("sb_gnt_left", gnt_q.size(), 64'd0);
        check_eq("sb_ack_left", ack_q.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
